// File: rtl/ram_port_arbiter.sv
`default_nettype none
// ============================================================================
// ram_port_arbiter: round-robin two-master arbiter/sequencer for a 32x8 RAM
// Revision: 1.0
// ============================================================================
module ram_port_arbiter #(
  parameter int AW = 5,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0_i,
  input  logic          we0_i,
  input  logic [AW-1:0] addr0_i,
  input  logic [DW-1:0] wdata0_i,
  output logic          ack0_o,
  input  logic          req1_i,
  input  logic          we1_i,
  input  logic [AW-1:0] addr1_i,
  input  logic [DW-1:0] wdata1_i,
  output logic          ack1_o,
  output logic [DW-1:0] rdata_o,
  output logic          busy_o,
  output logic          ram_cs_o,
  output logic          ram_we_o,
  output logic          ram_re_o,
  output logic          ram_oe_o,
  output logic [AW-1:0] ram_addr_o,
  output logic [DW-1:0] ram_din_o,
  input  logic [DW-1:0] ram_dout_i
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WR   = 3'd1,
    S_RD   = 3'd2,
    S_CAP  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic          ptr_q, ptr_d;
  logic          win_q, win_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] rdata_q, rdata_d;

  logic w_cs, w_we, w_re, w_oe, w_ack0, w_ack1;

  // Master 1 wins when it is the only requester, or both request and it holds priority.
  logic w_pick1;
  assign w_pick1 = req1_i & (~req0_i | ptr_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      ptr_q   <= 1'b0;
      win_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    w_cs    = 1'b0;
    w_we    = 1'b0;
    w_re    = 1'b0;
    w_oe    = 1'b0;
    w_ack0  = 1'b0;
    w_ack1  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req0_i | req1_i) begin
          win_d   = w_pick1;
          we_d    = w_pick1 ? we1_i    : we0_i;
          addr_d  = w_pick1 ? addr1_i  : addr0_i;
          wdata_d = w_pick1 ? wdata1_i : wdata0_i;
          state_d = we_d ? S_WR : S_RD;
        end
      end
      S_WR: begin
        w_cs    = 1'b1;
        w_we    = 1'b1;
        state_d = S_DONE;
      end
      S_RD: begin
        w_cs    = 1'b1;
        w_re    = 1'b1;
        state_d = S_CAP;
      end
      S_CAP: begin
        // Output enable exposes the word latched during RD; the repeat read is harmless.
        w_cs    = 1'b1;
        w_re    = 1'b1;
        w_oe    = 1'b1;
        rdata_d = ram_dout_i;
        state_d = S_DONE;
      end
      S_DONE: begin
        w_ack0  = ~win_q;
        w_ack1  = win_q;
        ptr_d   = ~win_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Reset masks the strobes immediately so an aborted transfer never touches the RAM.
  assign ram_cs_o   = w_cs & ~rst;
  assign ram_we_o   = w_we & ~rst;
  assign ram_re_o   = w_re & ~rst;
  assign ram_oe_o   = w_oe & ~rst;
  assign ack0_o     = w_ack0 & ~rst;
  assign ack1_o     = w_ack1 & ~rst;
  assign ram_addr_o = addr_q;
  assign ram_din_o  = wdata_q;
  assign rdata_o    = rdata_q;
  assign busy_o     = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_ram_port_arbiter.sv
`default_nettype none
// ============================================================================
// tb_ram_port_arbiter: self-checking bench with a RAM model and a cycle model
// Revision: 1.0
// ============================================================================
module tb_ram_port_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req0_i = 1'b0, we0_i = 1'b0, req1_i = 1'b0, we1_i = 1'b0;
  logic [4:0] addr0_i = '0, addr1_i = '0;
  logic [7:0] wdata0_i = '0, wdata1_i = '0;
  logic       ack0_o, ack1_o, busy_o;
  logic       ram_cs_o, ram_we_o, ram_re_o, ram_oe_o;
  logic [4:0] ram_addr_o;
  logic [7:0] ram_din_o, ram_dout_i, rdata_o;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int ack_log[$];

  ram_port_arbiter #(.AW(5), .DW(8)) dut (
    .clk(clk), .rst(rst),
    .req0_i(req0_i), .we0_i(we0_i), .addr0_i(addr0_i), .wdata0_i(wdata0_i), .ack0_o(ack0_o),
    .req1_i(req1_i), .we1_i(we1_i), .addr1_i(addr1_i), .wdata1_i(wdata1_i), .ack1_o(ack1_o),
    .rdata_o(rdata_o), .busy_o(busy_o),
    .ram_cs_o(ram_cs_o), .ram_we_o(ram_we_o), .ram_re_o(ram_re_o), .ram_oe_o(ram_oe_o),
    .ram_addr_o(ram_addr_o), .ram_din_o(ram_din_o), .ram_dout_i(ram_dout_i)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] init_val(input int i);
    return 8'((i * 3) + 1);
  endfunction

  // Behavioural model of the attached 32x8 RAM.
  logic [7:0] ram_mem [32];
  logic [7:0] ram_rreg = 8'h00;
  bit         ram_inited = 1'b0;
  always @(posedge clk) begin
    if (!ram_inited) begin
      for (int i = 0; i < 32; i++) ram_mem[i] <= init_val(i);
      ram_inited <= 1'b1;
    end else begin
      if (ram_cs_o && ram_we_o) ram_mem[ram_addr_o] <= ram_din_o;
      if (ram_cs_o && ram_re_o) ram_rreg <= ram_mem[ram_addr_o];
    end
  end
  assign ram_dout_i = (ram_cs_o && ram_re_o && ram_oe_o) ? ram_rreg : 8'hEE;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  // Transaction model: a grant in cycle g occupies cycles g+1.. with fixed offsets.
  initial begin : compare
    bit         act, mwr, mwin, mptr;
    int         start, off;
    logic [4:0] maddr;
    logic [7:0] mdin, mrdata;
    logic [7:0] mmem [32];
    for (int i = 0; i < 32; i++) mmem[i] = init_val(i);
    act = 0; mwr = 0; mwin = 0; mptr = 0; start = 0;
    maddr = '0; mdin = '0; mrdata = '0;
    forever begin
      @(negedge clk);
      off = cyc - start;
      if (cyc >= 1) begin
        chk("busy",     {31'b0, busy_o},   {31'b0, act});
        chk("ram_cs",   {31'b0, ram_cs_o}, {31'b0, !rst && act && (mwr ? off == 0 : off <= 1)});
        chk("ram_we",   {31'b0, ram_we_o}, {31'b0, !rst && act && mwr && off == 0});
        chk("ram_re",   {31'b0, ram_re_o}, {31'b0, !rst && act && !mwr && off <= 1});
        chk("ram_oe",   {31'b0, ram_oe_o}, {31'b0, !rst && act && !mwr && off == 1});
        chk("ack0",     {31'b0, ack0_o},   {31'b0, !rst && act && (off == (mwr ? 1 : 2)) && !mwin});
        chk("ack1",     {31'b0, ack1_o},   {31'b0, !rst && act && (off == (mwr ? 1 : 2)) && mwin});
        chk("ram_addr", {27'b0, ram_addr_o}, {27'b0, maddr});
        chk("ram_din",  {24'b0, ram_din_o},  {24'b0, mdin});
        chk("rdata",    {24'b0, rdata_o},    {24'b0, mrdata});
      end
      if (rst) begin
        act = 0; mptr = 0; maddr = '0; mdin = '0; mrdata = '0;
      end else if (act) begin
        if (mwr && off == 0) mmem[maddr] = mdin;
        if (!mwr && off == 1) mrdata = mmem[maddr];
        if (off == (mwr ? 1 : 2)) begin
          act = 0;
          mptr = !mwin;
        end
      end else if (req0_i || req1_i) begin
        mwin  = (req0_i && req1_i) ? mptr : req1_i;
        mwr   = mwin ? we1_i : we0_i;
        maddr = mwin ? addr1_i : addr0_i;
        mdin  = mwin ? wdata1_i : wdata0_i;
        act   = 1;
        start = cyc + 1;
      end
    end
  end

  // One master transaction; returns read data and request-to-ack latency in cycles.
  task automatic op(input int m, input bit w, input logic [4:0] a, input logic [7:0] d,
                    output logic [7:0] rd, output int lat);
    int t0;
    bit got;
    if (m == 0) begin req0_i = 1; we0_i = w; addr0_i = a; wdata0_i = d; end
    else        begin req1_i = 1; we1_i = w; addr1_i = a; wdata1_i = d; end
    t0 = cyc; got = 0; rd = '0; lat = -1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if ((m == 0 && ack0_o) || (m == 1 && ack1_o)) begin
        got = 1; rd = rdata_o; lat = cyc - t0;
        ack_log.push_back(m);
        break;
      end
    end
    if (!got) begin
      checks++; failures++;
      $display("FAIL ack_timeout master%0d: actual=no ack required=ack within 40 cycles", m);
    end
    @(posedge clk); #1;
    if (m == 0) req0_i = 0; else req1_i = 0;
  endtask

  initial begin : stim
    logic [7:0] rd;
    int lat;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("idle_busy", {31'b0, busy_o}, 32'd0);
    chk("idle_cs", {31'b0, ram_cs_o}, 32'd0);
    @(posedge clk); #1;

    op(0, 1, 5'd3, 8'hA5, rd, lat);
    chk("wr_latency", lat, 32'd2);
    op(1, 0, 5'd3, 8'h00, rd, lat);
    chk("rd_latency", lat, 32'd3);
    chk("rd_addr3", {24'b0, rd}, 32'hA5);

    ack_log.delete();
    fork
      begin
        logic [7:0] r0; int l0;
        for (int i = 0; i < 4; i++) op(0, 1, 5'(2 * i), 8'(8'h10 + 2 * i), r0, l0);
      end
      begin
        logic [7:0] r1; int l1;
        for (int i = 0; i < 4; i++) op(1, 1, 5'(2 * i + 1), 8'(8'h11 + 2 * i), r1, l1);
      end
    join
    chk("alt_count", ack_log.size(), 32'd8);
    for (int i = 0; i < ack_log.size(); i++) chk("alt_order", ack_log[i], i % 2);
    for (int i = 0; i < 8; i++) begin
      op(i % 2, 0, 5'(i), 8'h00, rd, lat);
      chk("readback", {24'b0, rd}, 8'h10 + i);
    end

    op(0, 1, 5'd9, 8'h77, rd, lat);
    req0_i = 1; we0_i = 1; addr0_i = 5'd9; wdata0_i = 8'h3C;
    @(posedge clk); #1;
    rst = 1; req0_i = 0;
    @(posedge clk); #1;
    rst = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("abort_no_ack", {31'b0, ack0_o}, 32'd0);
    end
    @(posedge clk); #1;
    op(1, 0, 5'd9, 8'h00, rd, lat);
    chk("abort_addr9", {24'b0, rd}, 32'h77);

    op(0, 1, 5'd31, 8'hFF, rd, lat);
    op(1, 0, 5'd31, 8'h00, rd, lat);
    chk("rd_addr31", {24'b0, rd}, 32'hFF);
    op(0, 0, 5'd0, 8'h00, rd, lat);
    chk("rd_addr0", {24'b0, rd}, 32'h10);

    repeat (3) @(posedge clk);
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
